// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the FPGA configuration loader.
package fpga_cfg_pkg;

    localparam int CFG_W_DEF  = 2828;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_e;

    function automatic int nwords(input int cfg_w, input int data_w);
        return (cfg_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_checksum.sv
// Running XOR over configuration data words; clear has priority over enable.
module cfg_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams a configuration image into a shadow register and commits it to the
// fabric only after the trailing XOR checksum word matches.
//
// state | meaning
// IDLE  | waiting for start; active image (if any) drives the fabric
// LOAD  | accepting data words, then the checksum word
// CHECK | one cycle: compare checksum, commit or flag error on exit
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_W  = CFG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [CFG_W-1:0]  cfg,
    output logic              cfg_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NWORDS = nwords(CFG_W, DATA_W);
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS);

    cfg_state_e state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [CFG_W-1:0]  shadow;
    logic [DATA_W-1:0] chk_word;
    logic [DATA_W-1:0] acc;
    logic              xfer;
    logic              load_start;
    logic              data_xfer;
    logic              chk_xfer;

    assign xfer       = s_valid && s_ready;
    assign load_start = (state == IDLE) && start;
    assign data_xfer  = xfer && (cnt != LAST_CNT);
    assign chk_xfer   = xfer && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (chk_xfer) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            CHECK:   busy = 1'b1;
            default: ;
        endcase
    end

    // One register per word slice; the last slice keeps only bits below CFG_W.
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        localparam int LO = k * DATA_W;
        localparam int W  = ((CFG_W - LO) < DATA_W) ? (CFG_W - LO) : DATA_W;
        logic [W-1:0] word_q;

        always_ff @(posedge clk) begin
            if (rst || load_start) begin
                word_q <= '0;
            end else if (data_xfer && (cnt == CNT_W'(k))) begin
                word_q <= s_data[W-1:0];
            end
        end

        assign shadow[LO +: W] = word_q;
    end

    cfg_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_start),
        .enable (data_xfer),
        .data   (s_data),
        .sum    (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            chk_word  <= '0;
            cfg       <= '0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_start) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (data_xfer) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (chk_xfer) begin
                chk_word <= s_data;
            end
            if (state == CHECK) begin
                done <= 1'b1;
                if (chk_word == acc) begin
                    cfg       <= shadow;
                    cfg_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader at CFG_W=20, DATA_W=8 (three data words).
module tb_fpga_cfg_loader;

    localparam int CFG_W  = 20;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [CFG_W-1:0]  cfg;
    logic              cfg_valid;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    fpga_cfg_loader #(
        .CFG_W  (CFG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0]  w0, w1, w2, chk;
        int          gap;
        logic [19:0] e_cfg;
        logic        e_valid;
        logic        e_err;
    } vec_t;

    vec_t tbl[5];

    int n_vec = 0;
    int n_bad = 0;

    // Reference state of the visible outputs
    logic [19:0] m_cfg;
    logic        m_valid;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [19:0] image_of(input logic [7:0] w0, w1, w2);
        int v;
        v = int'(w0) + int'(w1) * 256 + int'(w2) * 65536;
        return 20'(v % (1 << 20));
    endfunction

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            tick;
            check("busy_gap", 32'(busy), 32'd1);
            check("cfg_hold", 32'(cfg), 32'(m_cfg));
        end
        s_valid = 1'b1;
        s_data  = w;
        check("s_ready_load", 32'(s_ready), 32'd1);
        tick;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic begin_load;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_load", 32'(busy), 32'd1);
        check("err_clr", 32'(err), 32'd0);
    endtask

    // Called at the negedge inside CHECK, right after the checksum handshake edge
    task automatic finish_load(input logic [19:0] e_cfg, input logic e_valid, input logic e_err);
        check("busy_chk", 32'(busy), 32'd1);
        check("done_early", 32'(done), 32'd0);
        check("cfg_chk", 32'(cfg), 32'(m_cfg));
        tick;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("cfg_end", 32'(cfg), 32'(e_cfg));
        check("cfg_valid_end", 32'(cfg_valid), 32'(e_valid));
        check("err_end", 32'(err), 32'(e_err));
        tick;
        check("done_low", 32'(done), 32'd0);
        m_cfg   = e_cfg;
        m_valid = e_valid;
        m_err   = e_err;
    endtask

    task automatic run_load(input logic [7:0] w0, w1, w2, chk, input int gap, input bit rnd,
                            input logic [19:0] e_cfg, input logic e_valid, input logic e_err);
        begin_load;
        send_word(w0, rnd ? int'($urandom_range(0, gap)) : gap);
        send_word(w1, rnd ? int'($urandom_range(0, gap)) : gap);
        send_word(w2, rnd ? int'($urandom_range(0, gap)) : gap);
        send_word(chk, rnd ? int'($urandom_range(0, gap)) : gap);
        finish_load(e_cfg, e_valid, e_err);
    endtask

    initial begin
        logic [7:0]  w0, w1, w2, x, chk;
        bit          good;

        tbl[0] = '{8'h11, 8'h22, 8'h03, 8'h30, 0, 20'h32211, 1'b1, 1'b0};
        tbl[1] = '{8'h11, 8'h22, 8'h03, 8'h31, 0, 20'h32211, 1'b1, 1'b1};
        tbl[2] = '{8'h11, 8'h22, 8'h03, 8'h30, 3, 20'h32211, 1'b1, 1'b0};
        tbl[3] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 1, 20'hF55AA, 1'b1, 1'b0};
        tbl[4] = '{8'h01, 8'h02, 8'hF4, 8'h07, 2, 20'hF55AA, 1'b1, 1'b1};

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        tick;
        start = 1'b1;   // reset wins over start
        tick;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_cfg", 32'(cfg), 32'd0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_load(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].chk, tbl[i].gap, 1'b0,
                     tbl[i].e_cfg, tbl[i].e_valid, tbl[i].e_err);
        end

        for (int i = 0; i < 24; i++) begin
            w0   = 8'($urandom);
            w1   = 8'($urandom);
            w2   = 8'($urandom);
            x    = w0 ^ w1 ^ w2;
            good = bit'($urandom_range(0, 1));
            chk  = good ? x : (x ^ (8'h01 << $urandom_range(0, 7)));
            if (good) run_load(w0, w1, w2, chk, 2, 1'b1, image_of(w0, w1, w2), 1'b1, 1'b0);
            else      run_load(w0, w1, w2, chk, 2, 1'b1, m_cfg, m_valid, 1'b1);
        end

        // Reset after two words, with start and a handshake in the same cycle
        run_load(8'h11, 8'h22, 8'h03, 8'h30, 0, 1'b0, 20'h32211, 1'b1, 1'b0);
        begin_load;
        send_word(8'h44, 0);
        send_word(8'h55, 1);
        s_valid = 1'b1;
        s_data  = 8'h66;
        start   = 1'b1;
        rst     = 1'b1;
        tick;
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_cfg", 32'(cfg), 32'd0);
        check("mid_rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        run_load(8'h11, 8'h22, 8'h03, 8'h30, 0, 1'b0, 20'h32211, 1'b1, 1'b0);

        // s_valid while idle, and start repeated mid-load, must change nothing
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle_s_ready", 32'(s_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        begin_load;
        send_word(8'h5A, 0);
        start = 1'b1;
        send_word(8'hC3, 0);
        send_word(8'h07, 1);
        start = 1'b0;
        send_word(8'h9E, 0);
        finish_load(20'h7C35A, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter CFG_W, default 2828, total configuration bits (routing, switch, logic and IO selects concatenated, LSB first).
REQ-002 SHALL have parameter DATA_W, default 8, width of one configuration word.
REQ-003 SHALL define NWORDS = ceil(CFG_W/DATA_W), with default 354 data words.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begins a load when idle.
REQ-008 SHALL have port s_data, input, DATA_W bits: configuration word.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 SHALL have port s_ready, output, 1 bit: loader accepts a word.
REQ-011 SHALL have port cfg, output, CFG_W bits: active configuration driving the fabric.
REQ-012 SHALL have port cfg_valid, output, 1 bit: cfg holds a checksum-verified image.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of every load.
REQ-015 SHALL have port err, output, 1 bit: last load failed its checksum; sticky.

Function
REQ-016 SHALL implement states IDLE, LOAD and CHECK.
REQ-017 IDLE SHALL go to LOAD when start=1; start in LOAD or CHECK SHALL be ignored.
REQ-018 Entering LOAD SHALL clear the word counter, the shadow register, the checksum accumulator and err.
REQ-019 s_ready SHALL be 1 only in LOAD; a word transfers only when s_valid&&s_ready.
REQ-020 Word k (k < NWORDS) SHALL write shadow bits [k*DATA_W +: DATA_W]; bits above CFG_W-1 SHALL be discarded.
REQ-021 The accumulator SHALL XOR in every full data word, padding bits included.
REQ-022 Word NWORDS SHALL be the checksum word; its transfer SHALL move LOAD to CHECK, and it SHALL NOT be written to the shadow register.
REQ-023 CHECK SHALL last exactly one cycle, then go to IDLE.
REQ-024 If the checksum word equals the accumulator, then on the cycle after CHECK: cfg shall equal the shadow register and cfg_valid shall be 1.
REQ-025 On mismatch, then on the cycle after CHECK: cfg and cfg_valid shall be unchanged and err shall be 1.
REQ-026 done SHALL be 1 for exactly the cycle after CHECK, which is two cycles after the checksum handshake.
REQ-027 busy SHALL be 1 in LOAD and CHECK.
REQ-028 Gaps in s_valid SHALL stall without side effects; s_data SHALL be ignored when no transfer occurs.
REQ-029 cfg SHALL never change during LOAD; the previous image stays active until a successful commit.
REQ-030 The word counter SHALL be ceil(log2(NWORDS+1)) bits and SHALL never wrap.

Reset
REQ-031 rst SHALL force IDLE and clear cfg, cfg_valid, err, done, busy, the counter, the shadow register and the accumulator, including when asserted mid-load or in CHECK.
REQ-032 rst SHALL have priority over start and over any handshake in the same cycle.

Structure
REQ-033 Package fpga_cfg_pkg SHALL hold the state enum, default CFG_W/DATA_W and an nwords(CFG_W,DATA_W) function.
REQ-034 The checksum accumulator SHALL be sub-module cfg_checksum (clear, enable, data in, running XOR out).

Verification (CFG_W=20, DATA_W=8, NWORDS=3)
REQ-035 start, words 0x11,0x22,0x03, checksum 0x30 -> cfg=20'h32211, cfg_valid=1, err=0, done pulse 2 cycles after checksum handshake.
REQ-036 start, words 0x11,0x22,0x03, checksum 0x31 -> err=1, done pulse, cfg and cfg_valid unchanged.
REQ-037 Scenario REQ-035 with s_valid low for 3 cycles between each word -> identical result; busy held throughout.
REQ-038 rst after 2 words transferred -> next cycle IDLE, cfg=0, cfg_valid=0, s_ready=0.
REQ-039 start pulsed during LOAD, and s_valid=1 while IDLE -> no restart, no transfer, counter unchanged.
REQ-040 Good load, then bad load -> cfg stays 20'h32211 and cfg_valid=1; err=1 set, then cleared by the next start.
